j1_io_fabric: RTL
=================

Name: j1_io_fabric

Overview:
Parametrised I/O interconnect between the J1 CPU I/O port and N memory-mapped peripherals. It replaces the hand-written chip-select case and read mux in the SoC top. Slot i decodes one 256-word page (BASE_PAGE+i), broadcasts strobes, address and write data, and muxes read data back. It adds an internal status page that traps unmapped accesses with sticky flags, a fault address, a saturating error counter, an interrupt, and an optional registered read path.

Parameters:
N_SLOTS, 5, number of peripheral slots (1..16)
BASE_PAGE, 8'h67, j1_io_addr[15:8] value of slot 0; slot i uses page BASE_PAGE+i
STAT_PAGE, 8'h7F, page of the internal status registers
DEFAULT_DATA, 16'h0666, read value for unmapped addresses
RD_PIPE, 0, 0 = combinational read mux; 1 = registered read data

Ports:
sys_clk_i  input  1  system clock
sys_rst_i  input  1  synchronous reset, active-high
j1_io_rd  input  1  CPU read strobe
j1_io_wr  input  1  CPU write strobe
j1_io_addr  input  16  CPU I/O address
j1_io_dout  input  16  CPU write data
j1_io_din  output  16  read data to CPU
per_cs  output  N_SLOTS  one-hot slot select; bit i = slot i
per_rd  output  1  read strobe, copy of j1_io_rd
per_wr  output  1  write strobe, copy of j1_io_wr
per_addr  output  8  j1_io_addr[7:0]
per_din  output  16  write data, copy of j1_io_dout
per_dout  input  16*N_SLOTS  read data; slot i on bits [16i+15:16i]
irq_err  output  1  unmapped-access interrupt

Behaviour:
- Decode is combinational. per_cs[i]=1 iff addr[15:8]==BASE_PAGE+i (8-bit compare, no wrap past 8'hFF). STAT_PAGE has priority over slot decode, so a slot whose page equals STAT_PAGE is unreachable. Unmatched pages give per_cs=0.
- per_rd, per_wr, per_addr and per_din are ungated pass-throughs. Peripherals qualify them with per_cs.
- Read mux output: selected slot's data, the status register value when on STAT_PAGE, or DEFAULT_DATA when unmapped.
- RD_PIPE=0: j1_io_din is the mux output in the same cycle.
- RD_PIPE=1: j1_io_din is registered on every clock; the value appears one cycle after the address. Reset value is DEFAULT_DATA.
- Unmapped event: (rd|wr) in a cycle where no slot and not STAT_PAGE is hit. rd and wr in the same cycle count as one event.
- Status registers, decoded on addr[7:0]:
  - 0x00 STATUS: bit0 ERR (sticky), bit1 CNT_SAT; bits15:8 = N_SLOTS (read-only); other bits read 0. Write with bit0=1 clears ERR and CNT_SAT (W1C).
  - 0x01 ERR_ADDR: address of the most recent unmapped event. Read-only.
  - 0x02 ERR_CNT: 16-bit saturating count of unmapped events; sets CNT_SAT when it reaches 16'hFFFF. Any write clears it to 0.
  - 0x03 CTRL: bit0 IRQ_EN, read/write.
  - Unlisted offsets read 0; writes to them are ignored.
- Simultaneous events:
  - ERR clear and new event in one cycle: ERR=1 (set wins).
  - ERR_CNT clear and new event in one cycle: ERR_CNT=1.
  - Accesses to STAT_PAGE are never errors.
- irq_err is registered: irq_err <= ERR & IRQ_EN. It deasserts the cycle after a clear.
- Reset (synchronous, sys_rst_i=1 at a clock edge):
  - ERR, CNT_SAT, ERR_ADDR, ERR_CNT, IRQ_EN and irq_err = 0.
  - Registered j1_io_din = DEFAULT_DATA.
  - Events in the reset cycle are discarded.
  - Combinational outputs keep following their inputs.

Optional Feature:
- Macro: IO_FABRIC_STATS_EN.
- Defined: per-slot 16-bit wrapping access counters, incremented once per cycle with per_cs[i] & (rd|wr). Counter i reads at STAT_PAGE offset 0x10+i. Writing any value to offset 0x10+i clears it; clear wins over a simultaneous increment. Counters reset to 0.
- Undefined: no counters are built, and offsets 0x10..0x1F read 0.

Test Plan:
- Defaults; rd at 0x6905 with slot2 driving 16'hBEEF -> per_cs=5'b00100, per_addr=8'h05, j1_io_din=16'hBEEF in the same cycle; rd at 0x6C00 -> per_cs=0, j1_io_din=16'h0666.
- Write 16'h0001 to 0x7F03; then wr at 0x1234 -> next reads give STATUS[0]=1, ERR_ADDR=16'h1234, ERR_CNT=1; irq_err=1 starting the cycle after the event's edge.
- W1C write to 0x7F00 in the same cycle as an unmapped rd at 0x0042 -> ERR stays 1, ERR_CNT increments, ERR_ADDR=16'h0042; a W1C write alone -> ERR=0, irq_err=0 one cycle later.
- Force ERR_CNT to 16'hFFFE (two more events) -> stays 16'hFFFF, CNT_SAT=1; write 0x7F02 -> ERR_CNT=0.
- RD_PIPE=1; rd at 0x6700 with slot0=16'h1234 -> j1_io_din=16'h1234 one cycle later; j1_io_din=16'h0666 after reset.
- IO_FABRIC_STATS_EN defined; 3 accesses to slot 1 -> 0x7F11 reads 3; write 0x7F11 -> reads 0; macro undefined -> reads 0.

Source files
------------

// File: rtl/j1_io_fabric_if.sv
// Bus bundle between the J1 I/O port, the fabric and its peripheral slots.
// master = system side (CPU strobes/address/data plus peripheral read data); slave = the fabric.
interface j1_io_fabric_if #(
  parameter int N_SLOTS = 5
);
  logic                   j1_io_rd;
  logic                   j1_io_wr;
  logic [15:0]            j1_io_addr;
  logic [15:0]            j1_io_dout;
  logic [15:0]            j1_io_din;
  logic [N_SLOTS-1:0]     per_cs;
  logic                   per_rd;
  logic                   per_wr;
  logic [7:0]             per_addr;
  logic [15:0]            per_din;
  logic [16*N_SLOTS-1:0]  per_dout;

  modport master (
    output j1_io_rd, j1_io_wr, j1_io_addr, j1_io_dout, per_dout,
    input  j1_io_din, per_cs, per_rd, per_wr, per_addr, per_din
  );

  modport slave (
    input  j1_io_rd, j1_io_wr, j1_io_addr, j1_io_dout, per_dout,
    output j1_io_din, per_cs, per_rd, per_wr, per_addr, per_din
  );
endinterface

// File: rtl/j1_io_fabric.sv
// J1 I/O interconnect: page decode to N peripheral slots, read mux, unmapped-access trap.
// Optional per-slot access counters are built when IO_FABRIC_STATS_EN is defined.
module j1_io_fabric #(
  parameter int          N_SLOTS      = 5,
  parameter logic [7:0]  BASE_PAGE    = 8'h67,
  parameter logic [7:0]  STAT_PAGE    = 8'h7F,
  parameter logic [15:0] DEFAULT_DATA = 16'h0666,
  parameter int          RD_PIPE      = 0
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  j1_io_fabric_if.slave   bus,
  output logic            irq_err
);

  logic [7:0]         page;
  logic [7:0]         offset;
  logic               stat_hit;
  logic               access;
  logic [N_SLOTS-1:0] cs;
  logic [15:0]        slot_rdata;
  logic [15:0]        stat_rdata;
  logic [15:0]        stats_rdata;
  logic [15:0]        mux_rdata;

  logic               err;
  logic               cnt_sat;
  logic [15:0]        err_addr;
  logic [15:0]        err_cnt;
  logic [15:0]        cnt_next;
  logic               irq_en;

  logic               unmapped_evt;
  logic               stat_wr;
  logic               w1c;
  logic               cnt_clr;
  logic               ctrl_wr;

  assign page     = bus.j1_io_addr[15:8];
  assign offset   = bus.j1_io_addr[7:0];
  assign stat_hit = (page == STAT_PAGE);
  assign access   = bus.j1_io_rd | bus.j1_io_wr;

  assign bus.per_rd   = bus.j1_io_rd;
  assign bus.per_wr   = bus.j1_io_wr;
  assign bus.per_addr = offset;
  assign bus.per_din  = bus.j1_io_dout;
  assign bus.per_cs   = cs;

  // 9-bit compare so slots past page 8'hFF never alias back onto low pages
  always_comb begin
    cs = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!stat_hit && ({1'b0, page} == ({1'b0, BASE_PAGE} + 9'(i)))) begin
        cs[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (cs[i]) begin
        slot_rdata = bus.per_dout[16*i +: 16];
      end
    end
  end

  always_comb begin
    stat_rdata = '0;
    case (offset)
      8'h00:   stat_rdata = {8'(N_SLOTS), 6'b0, cnt_sat, err};
      8'h01:   stat_rdata = err_addr;
      8'h02:   stat_rdata = err_cnt;
      8'h03:   stat_rdata = {15'b0, irq_en};
      default: stat_rdata = stats_rdata;
    endcase
  end

  always_comb begin
    mux_rdata = DEFAULT_DATA;
    if (stat_hit) begin
      mux_rdata = stat_rdata;
    end else if (|cs) begin
      mux_rdata = slot_rdata;
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_rd_pipe
      logic [15:0] din_q;
      always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
          din_q <= DEFAULT_DATA;
        end else begin
          din_q <= mux_rdata;
        end
      end
      assign bus.j1_io_din = din_q;
    end else begin : g_rd_comb
      assign bus.j1_io_din = mux_rdata;
    end
  endgenerate

  assign unmapped_evt = access & ~stat_hit & ~(|cs);
  assign stat_wr      = bus.j1_io_wr & stat_hit;
  assign w1c          = stat_wr & (offset == 8'h00) & bus.j1_io_dout[0];
  assign cnt_clr      = stat_wr & (offset == 8'h02);
  assign ctrl_wr      = stat_wr & (offset == 8'h03);

  // A clear and a new event in the same cycle leave the count at one
  always_comb begin
    cnt_next = err_cnt;
    if (cnt_clr) begin
      cnt_next = unmapped_evt ? 16'h0001 : 16'h0000;
    end else if (unmapped_evt && (err_cnt != 16'hFFFF)) begin
      cnt_next = err_cnt + 16'h0001;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      err      <= 1'b0;
      cnt_sat  <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
      irq_en   <= 1'b0;
      irq_err  <= 1'b0;
    end else begin
      if (unmapped_evt) begin
        err      <= 1'b1;
        err_addr <= bus.j1_io_addr;
      end else if (w1c) begin
        err <= 1'b0;
      end
      if (unmapped_evt && (cnt_next == 16'hFFFF)) begin
        cnt_sat <= 1'b1;
      end else if (w1c) begin
        cnt_sat <= 1'b0;
      end
      err_cnt <= cnt_next;
      if (ctrl_wr) begin
        irq_en <= bus.j1_io_dout[0];
      end
      irq_err <= err & irq_en;
    end
  end

`ifdef IO_FABRIC_STATS_EN
  logic [15:0] slot_cnt [N_SLOTS];

  // Clearing a counter takes priority over an access landing in the same cycle
  always_ff @(posedge sys_clk_i) begin
    for (int i = 0; i < N_SLOTS; i++) begin
      if (sys_rst_i) begin
        slot_cnt[i] <= '0;
      end else if (stat_wr && (offset == (8'h10 + 8'(i)))) begin
        slot_cnt[i] <= '0;
      end else if (cs[i] && access) begin
        slot_cnt[i] <= slot_cnt[i] + 16'h0001;
      end
    end
  end

  always_comb begin
    stats_rdata = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (offset == (8'h10 + 8'(i))) begin
        stats_rdata = slot_cnt[i];
      end
    end
  end
`else
  assign stats_rdata = '0;
`endif

endmodule
